ahb_dma_fifo_slv: RTL and testbench

- AHB-Lite responder that sits at the far end of the DMA controller's AHB master port, acting as a peripheral data source.
- A peripheral pushes words into an internal FIFO. The block raises `dma_req` when the FIFO level reaches a programmed threshold and drops it on `dma_ack`.
- The DMA master drains the FIFO by reading the DATA register. CTRL and STATUS registers are reachable over the same AHB-Lite port.

---
 rtl/ahb_pkg.sv | 30 +++
 rtl/fifo_sync.sv | 59 +++++
 rtl/ahb_dma_fifo_slv.sv | 167 ++++++++++++++++
 tb/tb_ahb_dma_fifo_slv.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, register map and field positions for the DMA FIFO responder.
// Pure constants/types; no logic.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CLR    = 2'd3;

  localparam int ST_EMPTY    = 16;
  localparam int ST_FULL     = 17;
  localparam int ST_OVF      = 18;
  localparam int ST_REQ      = 19;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_TH_LSB = 4;
  localparam int CLR_OVF     = 0;
  localparam int CLR_FLUSH   = 1;

  typedef enum logic [1:0] {RSP_IDLE, RSP_ERR1, RSP_ERR2} rsp_state_t;
  typedef enum logic {REQ_IDLE, REQ_ACTIVE} req_state_t;
endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with flush; flush beats push/pop, push into full and pop from empty are ignored.
// Read data is the combinational head word; level/full/empty update on the clock edge.
module fifo_sync #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic                   hclk,
  input  logic                   hreset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   LVL_ONE = (PW+1)'(1);
  localparam logic [PW:0]   LVL_MAX = (PW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (level == LVL_MAX);
  assign empty   = (level == '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge hclk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/ahb_dma_fifo_slv.sv
// AHB-Lite responder draining a peripheral-fed FIFO for a DMA master; zero-wait OKAY, two-cycle ERROR.
// Peripheral is backpressured by periph_ready (EN & ~full); dma_req is raised at the programmed level.
module ahb_dma_fifo_slv
  import ahb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  parameter int AW    = 8
) (
  input  logic          hclk,
  input  logic          hreset_n,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic [2:0]    hsize,
  input  logic          hwrite,
  input  logic [DW-1:0] hwdata,
  input  logic          hreadyin,
  output logic          hreadyout,
  output logic          hresp,
  output logic [DW-1:0] hrdata,
  input  logic          periph_valid,
  input  logic [DW-1:0] periph_data,
  output logic          periph_ready,
  output logic          dma_req,
  input  logic          dma_ack,
  output logic          irq_ovf
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  logic          en;
  logic [7:0]    thresh;
  logic          ovf;
  logic          wr_pend;
  logic [1:0]    wr_off;
  rsp_state_t    rsp_st;
  req_state_t    req_st;

  logic [DW-1:0] fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_empty;

  logic [1:0]    off;
  logic          acc, bad, rd_ok, wr_ok, err_go;
  logic          pop, push, flush, ovf_set, ovf_clr, ctrl_wr, clr_wr;
  logic [8:0]    level9, th_eff;
  logic [DW-1:0] status, ctrl_rd, rd_val;
  logic          unused;

  assign off    = haddr[3:2];
  // The ERR1 guard keeps a stray hreadyin=1 from overlapping a transfer with our stall cycle.
  assign acc    = hsel & hreadyin & htrans[1] & (rsp_st != RSP_ERR1);
  assign bad    = (hsize != HSIZE_WORD) | ((off == REG_DATA) & (hwrite | fifo_empty));
  assign rd_ok  = acc & ~hwrite & ~bad;
  assign wr_ok  = acc & hwrite & ~bad;
  assign err_go = acc & bad;
  assign pop    = rd_ok & (off == REG_DATA);

  assign ctrl_wr = wr_pend & (wr_off == REG_CTRL);
  assign clr_wr  = wr_pend & (wr_off == REG_CLR);
  assign flush   = clr_wr & hwdata[CLR_FLUSH];
  assign ovf_clr = clr_wr & hwdata[CLR_OVF];

  assign periph_ready = en & ~fifo_full;
  assign push         = periph_valid & periph_ready;
  assign ovf_set      = periph_valid & en & fifo_full;
  assign irq_ovf      = ovf;
  assign level9       = 9'(fifo_level);
  assign unused       = ^{haddr, htrans[0], hwdata};

  fifo_sync #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wdata    (periph_data),
    .rdata    (fifo_rdata),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    status           = '0;
    status[8:0]      = level9;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = ovf;
    status[ST_REQ]   = dma_req;
    ctrl_rd                     = '0;
    ctrl_rd[CTRL_EN]            = en;
    ctrl_rd[CTRL_TH_LSB +: 8]   = thresh;
    case (off)
      REG_DATA:   rd_val = fifo_rdata;
      REG_STATUS: rd_val = status;
      REG_CTRL:   rd_val = ctrl_rd;
      default:    rd_val = '0;
    endcase
  end

  // A zero threshold behaves as 1; anything beyond the FIFO saturates at DEPTH.
  always_comb begin
    if (thresh == 8'd0)              th_eff = 9'd1;
    else if ({1'b0, thresh} > DEPTH9) th_eff = DEPTH9;
    else                              th_eff = {1'b0, thresh};
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      en      <= 1'b0;
      thresh  <= '0;
      ovf     <= 1'b0;
      wr_pend <= 1'b0;
      wr_off  <= REG_DATA;
      hrdata  <= '0;
    end else begin
      wr_pend <= wr_ok;
      wr_off  <= off;
      if (ctrl_wr) begin
        en     <= hwdata[CTRL_EN];
        thresh <= hwdata[CTRL_TH_LSB +: 8];
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      hrdata <= rd_ok ? rd_val : '0;
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      rsp_st    <= RSP_IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
    end else if (rsp_st == RSP_ERR1) begin
      rsp_st    <= RSP_ERR2;
      hreadyout <= 1'b1;
      hresp     <= HRESP_ERROR;
    end else if (err_go) begin
      rsp_st    <= RSP_ERR1;
      hreadyout <= 1'b0;
      hresp     <= HRESP_ERROR;
    end else begin
      rsp_st    <= RSP_IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
    end
  end

  // Leaving REQ costs one cycle in IDLE, so an ack always yields a one-cycle gap before re-request.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      req_st  <= REQ_IDLE;
      dma_req <= 1'b0;
    end else if (req_st == REQ_ACTIVE) begin
      if (dma_ack || flush || !en) begin
        req_st  <= REQ_IDLE;
        dma_req <= 1'b0;
      end
    end else if (en && (level9 >= th_eff) && !flush) begin
      req_st  <= REQ_ACTIVE;
      dma_req <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ahb_dma_fifo_slv.sv
// Bench for ahb_dma_fifo_slv: register vector table, directed multi-cycle sequences,
// then randomized push/read/ack traffic against a queue-based reference model.
module tb_ahb_dma_fifo_slv;
  import ahb_pkg::*;

  localparam int DEPTH = 16;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        hsel;
  logic [7:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  wire         hreadyin;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        periph_valid;
  logic [31:0] periph_data;
  logic        periph_ready;
  logic        dma_req;
  logic        dma_ack;
  logic        irq_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  off;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs [15];
  logic        xerr;
  logic [31:0] xrd;

  // Single-slave system: the bus ready seen by the slave is its own ready.
  assign hreadyin = hreadyout;

  ahb_dma_fifo_slv #(.DEPTH(DEPTH), .DW(32), .AW(8)) dut (
    .hclk         (hclk),
    .hreset_n     (hreset_n),
    .hsel         (hsel),
    .haddr        (haddr),
    .htrans       (htrans),
    .hsize        (hsize),
    .hwrite       (hwrite),
    .hwdata       (hwdata),
    .hreadyin     (hreadyin),
    .hreadyout    (hreadyout),
    .hresp        (hresp),
    .hrdata       (hrdata),
    .periph_valid (periph_valid),
    .periph_data  (periph_data),
    .periph_ready (periph_ready),
    .dma_req      (dma_req),
    .dma_ack      (dma_ack),
    .irq_ovf      (irq_ovf)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr_phase(input logic [1:0] off, input logic wr, input logic [2:0] sz);
    hsel   = 1'b1;
    haddr  = {4'h0, off, 2'b00};
    htrans = HTRANS_NONSEQ;
    hwrite = wr;
    hsize  = sz;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
  endtask

  // One complete transfer; returns whether ERROR was seen and the read data.
  task automatic ahb_xfer(input logic [1:0] off, input logic wr, input logic [2:0] sz,
                          input logic [31:0] wd, output logic err, output logic [31:0] rd);
    addr_phase(off, wr, sz);
    tick();
    bus_idle();
    hwdata = wd;
    err = hresp;
    rd  = hrdata;
    if (hresp) begin
      chk1("err_cycle1_hreadyout", hreadyout, 1'b0);
      tick();
      chk1("err_cycle2_hreadyout", hreadyout, 1'b1);
      chk1("err_cycle2_hresp", hresp, 1'b1);
    end else begin
      chk1("okay_zero_wait", hreadyout, 1'b1);
    end
    tick();
  endtask

  task automatic push(input logic [31:0] d);
    periph_valid = 1'b1;
    periph_data  = d;
    tick();
    periph_valid = 1'b0;
  endtask

  function automatic int th_eff(input int th);
    if (th == 0) return 1;
    if (th > DEPTH) return DEPTH;
    return th;
  endfunction

  task automatic rand_phase(input int th, input int pv_pct, input int ncyc);
    logic        err;
    logic [31:0] rd;
    logic [31:0] q[$];
    int          m_err = 0;
    bit          m_req = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_rd_dp = 1'b0;
    logic [31:0] m_rd_exp = '0;
    int          lvl;
    bit          pv, do_rd, ack;
    logic [31:0] pd;
    ahb_xfer(REG_CLR, 1'b1, HSIZE_WORD, 32'h3, err, rd);
    ahb_xfer(REG_CTRL, 1'b1, HSIZE_WORD, (32'(th) << 4) | 32'h1, err, rd);
    for (int c = 0; c < ncyc; c++) begin
      chk1("rnd_periph_ready", periph_ready, q.size() < DEPTH);
      chk1("rnd_irq_ovf", irq_ovf, m_ovf);
      chk1("rnd_dma_req", dma_req, m_req);
      chk1("rnd_hreadyout", hreadyout, m_err != 1);
      chk1("rnd_hresp", hresp, m_err != 0);
      if (m_rd_dp) chk("rnd_hrdata", hrdata, m_rd_exp);

      pd    = $urandom();
      pv    = ($urandom_range(0, 99) < pv_pct);
      do_rd = (m_err != 1) && ($urandom_range(0, 99) < 40);
      ack   = ($urandom_range(0, 7) == 0);
      periph_valid = pv;
      periph_data  = pd;
      dma_ack      = ack;
      if (do_rd) addr_phase(REG_DATA, 1'b0, HSIZE_WORD);
      else       bus_idle();

      lvl = q.size();
      if (m_err == 1)               m_err = 2;
      else if (do_rd && lvl == 0)   m_err = 1;
      else                          m_err = 0;
      m_rd_dp = do_rd && (lvl > 0);
      if (m_rd_dp) m_rd_exp = q[0];
      if (pv && lvl == DEPTH) m_ovf = 1'b1;
      if (m_req) begin
        if (ack) m_req = 1'b0;
      end else if (lvl >= th_eff(th)) begin
        m_req = 1'b1;
      end
      if (m_rd_dp) void'(q.pop_front());
      if (pv && lvl < DEPTH) q.push_back(pd);
      tick();
    end
    periph_valid = 1'b0;
    dma_ack      = 1'b0;
    bus_idle();
    tick();
    tick();
  endtask

  initial begin
    vecs[0]  = '{REG_STATUS, 1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h0001_0000};
    vecs[1]  = '{REG_CTRL,   1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h0000_0000};
    vecs[2]  = '{REG_CTRL,   1'b1, HSIZE_WORD, 32'h0000_FFF1, 1'b0, 32'h0};
    vecs[3]  = '{REG_CTRL,   1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h0000_0FF1};
    vecs[4]  = '{REG_CTRL,   1'b1, 3'b001,     32'h0,        1'b1, 32'h0};
    vecs[5]  = '{REG_CTRL,   1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h0000_0FF1};
    vecs[6]  = '{REG_CLR,    1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h0000_0000};
    vecs[7]  = '{REG_DATA,   1'b1, HSIZE_WORD, 32'h5,        1'b1, 32'h0};
    vecs[8]  = '{REG_DATA,   1'b0, HSIZE_WORD, 32'h0,        1'b1, 32'h0};
    vecs[9]  = '{REG_STATUS, 1'b0, 3'b000,     32'h0,        1'b1, 32'h0};
    vecs[10] = '{REG_CTRL,   1'b1, HSIZE_WORD, 32'h41,       1'b0, 32'h0};
    vecs[11] = '{REG_CTRL,   1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h0000_0041};
    vecs[12] = '{REG_STATUS, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[13] = '{REG_STATUS, 1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h0001_0000};
    vecs[14] = '{REG_CLR,    1'b1, HSIZE_WORD, 32'h0,        1'b0, 32'h0};

    hreset_n = 1'b0;
    hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hsize = HSIZE_WORD;
    hwrite = 1'b0; hwdata = '0; periph_valid = 1'b0; periph_data = '0; dma_ack = 1'b0;
    tick();
    tick();
    chk1("rst_hreadyout", hreadyout, 1'b1);
    chk1("rst_hresp", hresp, 1'b0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk1("rst_dma_req", dma_req, 1'b0);
    chk1("rst_periph_ready", periph_ready, 1'b0);
    chk1("rst_irq_ovf", irq_ovf, 1'b0);
    hreset_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      ahb_xfer(vecs[i].off, vecs[i].wr, vecs[i].sz, vecs[i].wd, xerr, xrd);
      chk1($sformatf("vec%0d_err", i), xerr, vecs[i].exp_err);
      if (!vecs[i].wr && !vecs[i].exp_err)
        chk($sformatf("vec%0d_rdata", i), xrd, vecs[i].exp_rd);
    end

    // Threshold 4: request the cycle after the level reaches 4.
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
    chk1("thr_req_not_yet", dma_req, 1'b0);
    tick();
    chk1("thr_req_rise", dma_req, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ahb_xfer(REG_DATA, 1'b0, HSIZE_WORD, 32'h0, xerr, xrd);
      chk1("drain_err", xerr, 1'b0);
      chk("drain_data", xrd, 32'h10 + 32'(i));
    end
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    chk1("ack_drop", dma_req, 1'b0);
    repeat (3) tick();
    chk1("ack_stays_low_empty", dma_req, 1'b0);

    // Fill to full, then overflow.
    for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i));
    chk1("full_periph_ready", periph_ready, 1'b0);
    periph_valid = 1'b1;
    periph_data  = 32'hDEAD_BEEF;
    chk1("pre_ovf_irq", irq_ovf, 1'b0);
    tick();
    periph_valid = 1'b0;
    chk1("ovf_irq", irq_ovf, 1'b1);
    ahb_xfer(REG_STATUS, 1'b0, HSIZE_WORD, 32'h0, xerr, xrd);
    // Level 16 with EN set keeps the request up, so bit 19 is checked separately.
    chk("ovf_status", xrd & ~32'h0008_0000, 32'h0006_0010);
    chk1("ovf_status_req", xrd[ST_REQ], 1'b1);
    ahb_xfer(REG_CLR, 1'b1, HSIZE_WORD, 32'h1, xerr, xrd);
    chk1("ovf_cleared", irq_ovf, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ahb_xfer(REG_DATA, 1'b0, HSIZE_WORD, 32'h0, xerr, xrd);
      chk("drain8_data", xrd, 32'h100 + 32'(i));
    end
    chk1("lvl8_req", dma_req, 1'b1);
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    chk1("reack_gap", dma_req, 1'b0);
    tick();
    chk1("reack_rise", dma_req, 1'b1);
    ahb_xfer(REG_CLR, 1'b1, HSIZE_WORD, 32'h2, xerr, xrd);
    chk1("flush_req", dma_req, 1'b0);
    ahb_xfer(REG_STATUS, 1'b0, HSIZE_WORD, 32'h0, xerr, xrd);
    chk("flush_status", xrd, 32'h0001_0000);

    // Simultaneous push and pop at level 3.
    for (int i = 0; i < 3; i++) push(32'hA0 + 32'(i));
    addr_phase(REG_DATA, 1'b0, HSIZE_WORD);
    periph_valid = 1'b1;
    periph_data  = 32'hA3;
    tick();
    bus_idle();
    periph_valid = 1'b0;
    chk("pushpop_hrdata", hrdata, 32'hA0);
    chk1("pushpop_hresp", hresp, 1'b0);
    tick();
    ahb_xfer(REG_STATUS, 1'b0, HSIZE_WORD, 32'h0, xerr, xrd);
    chk("pushpop_status", xrd, 32'h0000_0003);

    // Reset in the middle of an ERROR response with a request outstanding.
    ahb_xfer(REG_CTRL, 1'b1, HSIZE_WORD, 32'h11, xerr, xrd);
    tick();
    chk1("pre_rst_req", dma_req, 1'b1);
    addr_phase(REG_DATA, 1'b1, HSIZE_WORD);
    tick();
    bus_idle();
    chk1("pre_rst_stall", hreadyout, 1'b0);
    #2 hreset_n = 1'b0;
    #1;
    chk1("midrst_hreadyout", hreadyout, 1'b1);
    chk1("midrst_hresp", hresp, 1'b0);
    chk("midrst_hrdata", hrdata, 32'h0);
    chk1("midrst_dma_req", dma_req, 1'b0);
    chk1("midrst_periph_ready", periph_ready, 1'b0);
    chk1("midrst_irq_ovf", irq_ovf, 1'b0);
    tick();
    hreset_n = 1'b1;
    tick();
    ahb_xfer(REG_STATUS, 1'b0, HSIZE_WORD, 32'h0, xerr, xrd);
    chk("post_rst_status", xrd, 32'h0001_0000);

    rand_phase(0, 60, 400);
    rand_phase(6, 30, 400);
    rand_phase(200, 50, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
